sa_ws_array: RTL and testbench

Parametrised weight-stationary systolic array for the conv datapath. It replaces the fixed 3×3, hard-wired-kernel array with ROWS×COLS PEs and run-time weight loading over a handshake. It has integrated input skew and output deskew, per-beat valid tagging with bubbles, global stall on output backpressure, and signed or unsigned mode. It sits between the ifmap line-buffer stream (one ROWS-wide vector per beat) and the psum accumulator/requantiser (one COLS-wide psum vector per beat).

---
 rtl/sa_ws_pkg.sv | 21 ++
 rtl/sa_ws_array_if.sv | 33 +++
 rtl/sa_ws_pe.sv | 43 ++++
 rtl/sa_ws_array.sv | 160 ++++++++++++++++
 tb/tb_sa_ws_array.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_ws_pkg.sv
// Shared types and helpers for the weight-stationary systolic array.
package sa_ws_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } sa_state_t;

   typedef struct packed {
      logic valid;
      logic last;
   } beat_tag_t;

   // Narrowest psum that holds a sum of ROWS full-range products exactly.
   function automatic int psum_width_min(input int data_width, input int rows);
      return 2 * data_width + $clog2(rows);
   endfunction

endpackage

// File: rtl/sa_ws_array_if.sv
// Weight, activation and psum streams of the systolic array plus its status.
interface sa_ws_array_if
   import sa_ws_pkg::*;
#(
   parameter int ROWS       = 3,
   parameter int COLS       = 3,
   parameter int DATA_WIDTH = 8,
   parameter int PSUM_WIDTH = psum_width_min(DATA_WIDTH, ROWS)
);
   logic                       cfg_signed;
   logic                       w_valid;
   logic                       w_ready;
   logic [COLS*DATA_WIDTH-1:0] w_data;
   logic                       a_valid;
   logic                       a_ready;
   logic [ROWS*DATA_WIDTH-1:0] a_data;
   logic                       a_last;
   logic                       o_valid;
   logic                       o_ready;
   logic [COLS*PSUM_WIDTH-1:0] o_data;
   logic                       o_last;
   logic                       busy;

   modport master (
      output cfg_signed, w_valid, w_data, a_valid, a_data, a_last, o_ready,
      input  w_ready, a_ready, o_valid, o_data, o_last, busy
   );

   modport slave (
      input  cfg_signed, w_valid, w_data, a_valid, a_data, a_last, o_ready,
      output w_ready, a_ready, o_valid, o_data, o_last, busy
   );
endinterface

// File: rtl/sa_ws_pe.sv
// One weight-stationary PE: multiplies the passing activation by its resident
// weight and adds the product to the psum flowing down the column.
module sa_ws_pe
   import sa_ws_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PSUM_WIDTH = 18
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  signed_mode,
   input  logic [DATA_WIDTH-1:0] weight,
   input  logic [DATA_WIDTH-1:0] ifmap_i,
   output logic [DATA_WIDTH-1:0] ifmap_o,
   input  logic [PSUM_WIDTH-1:0] psum_i,
   output logic [PSUM_WIDTH-1:0] psum_o
);
   localparam int PROD_W = 2 * DATA_WIDTH + 2;

   logic signed [PROD_W-1:0] act_ext;
   logic signed [PROD_W-1:0] wt_ext;
   logic signed [PROD_W-1:0] product;
   logic [PSUM_WIDTH-1:0]    product_ext;

   // Extending by the mode-gated sign bit lets one signed multiplier serve both modes.
   always_comb begin
      act_ext     = {{(PROD_W-DATA_WIDTH){signed_mode & ifmap_i[DATA_WIDTH-1]}}, ifmap_i};
      wt_ext      = {{(PROD_W-DATA_WIDTH){signed_mode & weight[DATA_WIDTH-1]}}, weight};
      product     = act_ext * wt_ext;
      product_ext = PSUM_WIDTH'(product);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ifmap_o <= '0;
         psum_o  <= '0;
      end else if (en) begin
         ifmap_o <= ifmap_i;
         psum_o  <= psum_i + product_ext;
      end
   end
endmodule

// File: rtl/sa_ws_array.sv
// Weight-stationary ROWS x COLS systolic array with input skew, output deskew,
// tagged beats and a global stall driven by output backpressure.
module sa_ws_array
   import sa_ws_pkg::*;
#(
   parameter int ROWS       = 3,
   parameter int COLS       = 3,
   parameter int DATA_WIDTH = 8,
   parameter int PSUM_WIDTH = psum_width_min(DATA_WIDTH, ROWS)
) (
   input logic          clk,
   input logic          nrst,
   sa_ws_array_if.slave bus
);
   localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DEPTH = ROWS + COLS + 1;

   sa_state_t             state, state_nxt;
   logic [CNT_W-1:0]      w_cnt;
   logic                  wts_loaded;
   logic                  signed_q;
   logic                  en;
   logic                  w_accept;
   logic                  a_accept;
   logic                  w_last_beat;
   logic [DATA_WIDTH-1:0] weights [ROWS][COLS];
   beat_tag_t             tags    [DEPTH];
   logic [DATA_WIDTH-1:0] row_in  [ROWS];
   logic [DATA_WIDTH-1:0] act     [ROWS][COLS];
   logic [PSUM_WIDTH-1:0] psum    [ROWS+1][COLS];

   assign en          = !(bus.o_valid && !bus.o_ready);
   assign w_last_beat = (w_cnt == CNT_W'(ROWS-1));
   assign w_accept    = bus.w_valid && bus.w_ready;
   assign a_accept    = bus.a_valid && bus.a_ready;
   assign bus.o_valid = tags[DEPTH-1].valid;
   assign bus.o_last  = tags[DEPTH-1].last;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      bus.w_ready = 1'b0;
      bus.a_ready = 1'b0;
      bus.busy    = (state != IDLE);
      case (state)
         IDLE: begin
            bus.w_ready = 1'b1;
            if (bus.w_valid)                    state_nxt = w_last_beat ? IDLE : LOAD;
            else if (bus.a_valid && wts_loaded) state_nxt = RUN;
         end
         LOAD: begin
            bus.w_ready = 1'b1;
            if (bus.w_valid && w_last_beat) state_nxt = IDLE;
         end
         RUN: begin
            bus.a_ready = en;
            if (bus.a_valid && en && bus.a_last) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (bus.o_valid && bus.o_ready && bus.o_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The first beat of a load (taken in IDLE) invalidates the old weights.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         w_cnt      <= '0;
         wts_loaded <= 1'b0;
         signed_q   <= 1'b0;
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               weights[r][c] <= '0;
      end else begin
         if (state == IDLE) signed_q <= bus.cfg_signed;
         if (w_accept) begin
            wts_loaded <= w_last_beat;
            w_cnt      <= w_last_beat ? '0 : w_cnt + 1'b1;
            for (int r = 0; r < ROWS; r++)
               if (w_cnt == CNT_W'(r))
                  for (int c = 0; c < COLS; c++)
                     weights[r][c] <= bus.w_data[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
      end else if (en) begin
         tags[0].valid <= a_accept;
         tags[0].last  <= a_accept && bus.a_last;
         for (int i = 1; i < DEPTH; i++) tags[i] <= tags[i-1];
      end
   end

   // Input capture plus r stages of skew; idle cycles shift in zero bubbles.
   for (genvar r = 0; r < ROWS; r++) begin : g_skew
      logic [DATA_WIDTH-1:0] stage [r+1];
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            for (int i = 0; i <= r; i++) stage[i] <= '0;
         end else if (en) begin
            stage[0] <= a_accept ? bus.a_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int i = 1; i <= r; i++) stage[i] <= stage[i-1];
         end
      end
      assign row_in[r] = stage[r];
   end

   for (genvar c = 0; c < COLS; c++) begin : g_psum_top
      assign psum[0][c] = '0;
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [DATA_WIDTH-1:0] unused_tail;
      assign unused_tail = act[r][COLS-1];
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [DATA_WIDTH-1:0] ifmap_in;
         if (c == 0) begin : g_edge
            assign ifmap_in = row_in[r];
         end else begin : g_inner
            assign ifmap_in = act[r][c-1];
         end
         sa_ws_pe #(
            .DATA_WIDTH (DATA_WIDTH),
            .PSUM_WIDTH (PSUM_WIDTH)
         ) u_pe (
            .clk         (clk),
            .nrst        (nrst),
            .en          (en),
            .signed_mode (signed_q),
            .weight      (weights[r][c]),
            .ifmap_i     (ifmap_in),
            .ifmap_o     (act[r][c]),
            .psum_i      (psum[r][c]),
            .psum_o      (psum[r+1][c])
         );
      end
   end

   // Column c leaves the array c cycles after column 0; the final stage is the output register.
   for (genvar c = 0; c < COLS; c++) begin : g_deskew
      logic [PSUM_WIDTH-1:0] stage [COLS-c];
      always_ff @(posedge clk or negedge nrst) begin
         if (!nrst) begin
            for (int i = 0; i < COLS-c; i++) stage[i] <= '0;
         end else if (en) begin
            stage[0] <= psum[ROWS][c];
            for (int i = 1; i < COLS-c; i++) stage[i] <= stage[i-1];
         end
      end
      assign bus.o_data[c*PSUM_WIDTH +: PSUM_WIDTH] = stage[COLS-c-1];
   end
endmodule

// File: tb/tb_sa_ws_array.sv
// Scoreboard bench for sa_ws_array: directed vectors push expected psums, a
// negedge monitor pops and compares them and watches stall stability.
module tb_sa_ws_array;
   import sa_ws_pkg::*;

   localparam int ROWS = 3;
   localparam int COLS = 3;
   localparam int DW   = 8;
   localparam int PW   = 18;
   localparam int OW   = COLS * PW;

   typedef struct {
      logic [OW-1:0] data;
      logic          last;
   } exp_t;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   logic toggle_ready = 1'b0;
   logic fixed_ready  = 1'b1;
   logic rand_ready   = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q [$];

   sa_ws_array_if #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .PSUM_WIDTH(PW)) bus ();

   sa_ws_array #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .PSUM_WIDTH(PW)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   assign bus.o_ready = toggle_ready ? rand_ready : fixed_ready;

   always #5 clk = ~clk;

   initial begin : ready_gen
      forever begin
         @(posedge clk);
         #2;
         rand_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: still running at time limit, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [OW-1:0] pack3(input int c0, input int c1, input int c2);
      return {PW'(c2), PW'(c1), PW'(c0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic loadWeights(input logic [ROWS*COLS*DW-1:0] w);
      int   n;
      logic acc;
      for (int r = 0; r < ROWS; r++) begin
         bus.w_valid = 1'b1;
         bus.w_data  = w[r*COLS*DW +: COLS*DW];
         n   = 0;
         acc = 1'b0;
         while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.w_ready;
            tick();
            n++;
         end
         checkOutput("w_beat_accepted", 64'(acc), 64'(1));
      end
      bus.w_valid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [ROWS*DW-1:0] a, input logic last, input logic [OW-1:0] expected);
      int   n;
      logic acc;
      bus.a_valid = 1'b1;
      bus.a_data  = a;
      bus.a_last  = last;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = bus.a_ready;
         @(posedge clk);
         if (acc) exp_q.push_back('{data: expected, last: last});
         #1;
         n++;
      end
      bus.a_valid = 1'b0;
      bus.a_last  = 1'b0;
      checkOutput("a_beat_accepted", 64'(acc), 64'(1));
   endtask

   task automatic waitIdle();
      int n = 0;
      while (bus.busy && n < 300) begin
         tick();
         n++;
      end
      checkOutput("return_to_idle", 64'(bus.busy), 64'(0));
      checkOutput("all_beats_out", 64'(exp_q.size()), 64'(0));
   endtask

   // Monitor: pops on every handshake and checks outputs held during stalls.
   initial begin : monitor
      exp_t          e;
      logic          held_valid;
      logic [OW-1:0] held_data;
      logic          held_last;
      held_valid = 1'b0;
      held_data  = '0;
      held_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (!nrst) begin
            held_valid = 1'b0;
         end else begin
            if (held_valid) begin
               checkOutput("stall_hold_valid", 64'(bus.o_valid), 64'(1));
               checkOutput("stall_hold_data", 64'(bus.o_data), 64'(held_data));
               checkOutput("stall_hold_last", 64'(bus.o_last), 64'(held_last));
            end
            if (bus.o_valid && bus.o_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected_beat: got o_data 0x%0h, expected no beat", bus.o_data);
               end else begin
                  e = exp_q.pop_front();
                  checkOutput("psum_data", 64'(bus.o_data), 64'(e.data));
                  checkOutput("psum_last", 64'(bus.o_last), 64'(e.last));
               end
            end
            held_valid = bus.o_valid && !bus.o_ready;
            held_data  = bus.o_data;
            held_last  = bus.o_last;
         end
      end
   end

   initial begin : stimulus
      logic [ROWS*DW-1:0] s_vec [8];
      int                 s_exp [8][3];
      s_vec = '{24'h000001, 24'h000100, 24'h010000, 24'h010101,
                24'h040302, 24'h1E140A, 24'h0100FF, 24'h070605};
      s_exp = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{12, 15, 18},
                '{42, 51, 60}, '{300, 360, 420}, '{262, 518, 774}, '{78, 96, 114}};

      bus.cfg_signed = 1'b0;
      bus.w_valid    = 1'b0;
      bus.w_data     = '0;
      bus.a_valid    = 1'b0;
      bus.a_data     = '0;
      bus.a_last     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b1;
      tick();

      $display("[TB] reset values");
      checkOutput("rst_w_ready", 64'(bus.w_ready), 64'(1));
      checkOutput("rst_a_ready", 64'(bus.a_ready), 64'(0));
      checkOutput("rst_o_valid", 64'(bus.o_valid), 64'(0));
      checkOutput("rst_o_last", 64'(bus.o_last), 64'(0));
      checkOutput("rst_o_data", 64'(bus.o_data), 64'(0));
      checkOutput("rst_busy", 64'(bus.busy), 64'(0));

      bus.a_valid = 1'b1;
      bus.a_data  = 24'h010101;
      repeat (4) begin
         tick();
         checkOutput("no_wts_a_ready", 64'(bus.a_ready), 64'(0));
         checkOutput("no_wts_busy", 64'(bus.busy), 64'(0));
      end
      bus.a_valid = 1'b0;

      $display("[TB] identity weights and latency");
      loadWeights({24'h010000, 24'h000100, 24'h000001});
      checkOutput("load_back_to_idle", 64'(bus.busy), 64'(0));
      applyStimulus(24'h030201, 1'b1, pack3(1, 2, 3));
      repeat (5) tick();
      checkOutput("latency_not_early", 64'(bus.o_valid), 64'(0));
      tick();
      checkOutput("latency_exact", 64'(bus.o_valid), 64'(1));
      checkOutput("busy_before_handshake", 64'(bus.busy), 64'(1));
      tick();
      checkOutput("busy_after_handshake", 64'(bus.busy), 64'(0));
      checkOutput("no_valid_after_last", 64'(bus.o_valid), 64'(0));

      $display("[TB] signed extremes");
      bus.cfg_signed = 1'b1;
      loadWeights({3{24'h808080}});
      applyStimulus(24'h02FF01, 1'b0, pack3(-256, -256, -256));
      applyStimulus(24'h808080, 1'b1, pack3(49152, 49152, 49152));
      waitIdle();

      $display("[TB] unsigned extremes");
      bus.cfg_signed = 1'b0;
      loadWeights({3{24'hFFFFFF}});
      applyStimulus(24'hFFFFFF, 1'b1, pack3(195075, 195075, 195075));
      waitIdle();

      $display("[TB] stream with gaps and backpressure");
      loadWeights({24'h090807, 24'h060504, 24'h030201});
      toggle_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         applyStimulus(s_vec[i], 1'(i == 7), pack3(s_exp[i][0], s_exp[i][1], s_exp[i][2]));
      end
      waitIdle();
      toggle_ready = 1'b0;

      $display("[TB] reload and weight request during drain");
      loadWeights({3{24'h010101}});
      applyStimulus(24'h030201, 1'b0, pack3(6, 6, 6));
      applyStimulus(24'h060504, 1'b1, pack3(15, 15, 15));
      bus.w_valid = 1'b1;
      bus.w_data  = 24'hFFFFFF;
      @(negedge clk);
      checkOutput("drain_w_ready", 64'(bus.w_ready), 64'(0));
      checkOutput("drain_busy", 64'(bus.busy), 64'(1));
      tick();
      bus.w_valid = 1'b0;
      waitIdle();
      applyStimulus(24'h010101, 1'b1, pack3(3, 3, 3));
      waitIdle();

      $display("[TB] reset during run");
      applyStimulus(24'h010203, 1'b0, pack3(6, 6, 6));
      applyStimulus(24'h020202, 1'b0, pack3(6, 6, 6));
      applyStimulus(24'h030303, 1'b0, pack3(9, 9, 9));
      tick();
      nrst = 1'b0;
      exp_q.delete();
      tick();
      checkOutput("reset_mid_o_valid", 64'(bus.o_valid), 64'(0));
      checkOutput("reset_mid_busy", 64'(bus.busy), 64'(0));
      tick();
      nrst = 1'b1;
      repeat (12) begin
         tick();
         checkOutput("post_reset_no_valid", 64'(bus.o_valid), 64'(0));
      end
      bus.a_valid = 1'b1;
      bus.a_data  = 24'h010101;
      repeat (4) begin
         tick();
         checkOutput("reload_required_busy", 64'(bus.busy), 64'(0));
         checkOutput("reload_required_a_ready", 64'(bus.a_ready), 64'(0));
      end
      bus.a_valid = 1'b0;
      loadWeights({24'h010000, 24'h000100, 24'h000001});
      applyStimulus(24'h090807, 1'b1, pack3(7, 8, 9));
      waitIdle();

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
